qspi_cmd_arbiter: RTL and testbench
===================================

# qspi_cmd_arbiter

Shares the single QSPI flash command interface (cmd_type / flash_cmd / flash_addr, done_sig / read_data) between two requesters, for example the flash test sequencer and a readback/verify master. It arbitrates round-robin and issues each granted request as one atomic transaction. For program, erase and config-write operations it automatically prefixes Write Enable (06h) and appends Read Status (05h) busy polling. Requesters see one request/ack handshake per operation.

## Interface
- POLL_MAX, default 16'hFFFF: maximum status polls before the transaction aborts with error.
- clk_25M  in  1  system clock.
- I_rst  in  1  **synchronous, active-high reset.**
- W_req0 / W_req1  in  1  request from port 0 / port 1; held high until the matching ack.
- W_req_type0 / W_req_type1  in  4  operation code (low 4 bits of cmd_type).
- W_req_cmd0 / W_req_cmd1  in  8  flash opcode.
- W_req_addr0 / W_req_addr1  in  24  flash address.
- W_req_data0 / W_req_data1  in  16  write payload (config register value / test vector).
- W_done_sig  in  1  driver transaction-complete pulse.
- W_read_data  in  8  driver read byte (ID / status).
- R_cmd_type  out  5  {start, op}; bit4 = command active.
- R_flash_cmd  out  8  opcode to driver.
- R_flash_addr  out  24  address to driver.
- R_wr_data  out  16  payload to driver.
- R_ack0 / R_ack1  out  1  one-cycle completion pulse.
- R_rdata0 / R_rdata1  out  8  read byte captured from the main op; valid while ack is high and held afterwards.
- R_err0 / R_err1  out  1  poll timeout; valid with ack.

## Operation
- Op codes: 0 read ID, 1 WREN, 2 sector erase, 3 read status, 5 page program, 6 write NV config, 8 quad page program.
- needs_wren = needs_poll = op ∈ {2, 5, 6, 8}.
- States:
  - IDLE: if any req, choose a port and latch its type/cmd/addr/data. Go to WREN if needs_wren, else OP.
  - WREN: drive 1_0001 / 06h until done.
  - GAP: one cycle with R_cmd_type = 0, then advance.
  - OP: drive {1, type} / cmd / addr / data until done; capture W_read_data. Go to POLL if needs_poll, else ACK (via GAP).
  - POLL: drive 1_0011 / 05h until done.
    - On done, if W_read_data[0] == 0, go to ACK.
    - Otherwise increment the poll count. If the count equals POLL_MAX, go to ACK with error; else go to GAP and then back to POLL.
  - ACK: pulse ack, rdata and err to the granted port; update the round-robin pointer; go to IDLE.
- Round robin:
  - The pointer holds the last-served port; reset value = 1, so port 0 wins the first tie.
  - With both requests high, grant the port not last served.
  - With one request high, grant it regardless of the pointer.
- Command outputs stay stable for the whole active period. R_flash_cmd and R_cmd_type return to 0 in GAP, ACK and IDLE. R_flash_addr and R_wr_data hold their last value.
- W_done_sig is ignored unless R_cmd_type[4] = 1.
- Requester field changes after grant are ignored; the latched copy is used.

## Timing
- All outputs are registered.
- Reset values: R_cmd_type 0, R_flash_cmd 0, R_flash_addr 0, R_wr_data 0, R_ack* 0, R_rdata* 0, R_err* 0, state IDLE, poll count 0, pointer 1.
- Request latency: req sampled high in IDLE at edge k → R_cmd_type[4] = 1 from edge k+1.
- Done handling: W_done_sig high at edge d → R_cmd_type = 0 from edge d+1 for exactly one cycle; the next command asserts at edge d+2.
- Completion: done of the final command at edge d → ack high from edge d+2 (after GAP) for one cycle. IDLE is re-entered at d+3, and arbitration can grant at that edge.
- Requester rules:
  - The requester must drop req in the cycle after ack.
  - A req still high at the IDLE evaluation is treated as a new request.
- A done arriving in the same cycle the arbiter drives start counts as completion of that command.
- Reset mid-transaction: all outputs go to reset values at the next edge. No ack is issued. A still-pending req is re-arbitrated from scratch after reset releases.
- Poll count is 16 bits, cleared on entry to WREN/OP, and saturates at POLL_MAX.

## Structure
- Shared package qspi_cmd_pkg: op-code constants (CMD_RDID 0, CMD_WREN 1, CMD_SE 2, CMD_RDSR 3, CMD_PP 5, CMD_WNVCR 6, CMD_QPP 8), opcode constants 06h/05h, needs_wren/needs_poll function, state enum.
- Sub-module qspi_rr_arb2: two-input round-robin grant with a last-served pointer. Pointer update is enabled by ACK.

## Test plan
- Port 0 read ID (type 0, 9Fh); driver model returns 0x20 after 10 cycles → exactly one 1_0000/9Fh command, no WREN, R_ack0 with R_rdata0 = 0x20, R_err0 = 0.
- Port 1 sector erase (type 2, D8h, addr 0x010000); status sequence 0x01, 0x01, 0x00 → sequence is 1_0001/06h, 1_0010/D8h/0x010000, then three 1_0011/05h polls, each separated by a one-cycle zero gap; then R_ack1, R_err1 = 0.
- Both ports request quad page program simultaneously and repeatedly → grants alternate 0, 1, 0, 1; no transaction interleaving.
- POLL_MAX = 4, status stuck at 0x01 → exactly 4 polls, then ack with err = 1, then IDLE.
- I_rst asserted during a POLL for one cycle, with req0 still high → outputs zero at next edge, no ack; after release, the transaction restarts with WREN.
- Spurious W_done_sig in IDLE and during GAP → no state change, no ack; every genuine done is followed by exactly one cycle with R_cmd_type = 0.

Source files
------------

// File: rtl/qspi_cmd_pkg.sv
// Shared definitions for the QSPI command arbiter: operation codes,
// flash opcodes, FSM state encoding and the write-sequence helpers.
package qspi_cmd_pkg;

   localparam logic [3:0] CMD_RDID  = 4'd0;
   localparam logic [3:0] CMD_WREN  = 4'd1;
   localparam logic [3:0] CMD_SE    = 4'd2;
   localparam logic [3:0] CMD_RDSR  = 4'd3;
   localparam logic [3:0] CMD_PP    = 4'd5;
   localparam logic [3:0] CMD_WNVCR = 4'd6;
   localparam logic [3:0] CMD_QPP   = 4'd8;

   localparam logic [7:0] OPC_WREN = 8'h06;
   localparam logic [7:0] OPC_RDSR = 8'h05;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WREN,
      ST_GAP,
      ST_OP,
      ST_POLL,
      ST_ACK
   } state_t;

   // Operations that modify the array need a Write Enable in front.
   function automatic logic needs_wren(input logic [3:0] op);
      return (op == CMD_SE) || (op == CMD_PP) || (op == CMD_WNVCR) || (op == CMD_QPP);
   endfunction

   // The same operations leave the device busy and must be polled.
   function automatic logic needs_poll(input logic [3:0] op);
      return needs_wren(op);
   endfunction

endpackage

// File: rtl/qspi_rr_arb2.sv
// Two-port round-robin grant. The pointer remembers the last served port;
// on a tie the other port wins, a lone request always wins.
module qspi_rr_arb2 (
   input  logic clk_25M,
   input  logic I_rst,
   input  logic req0,
   input  logic req1,
   input  logic upd_en,
   input  logic upd_port,
   output logic gnt_valid,
   output logic gnt_port
);

   logic last_port;

   // Grant selection from the current requests and the last-served pointer.
   always_comb begin
      gnt_valid = req0 | req1;
      if (req0 && req1) begin
         gnt_port = ~last_port;
      end else begin
         gnt_port = req1;
      end
   end

   // Pointer resets to port 1 so port 0 wins the first tie.
   always_ff @(posedge clk_25M) begin
      if (I_rst) begin
         last_port <= 1'b1;
      end else if (upd_en) begin
         last_port <= upd_port;
      end
   end

endmodule

// File: rtl/qspi_cmd_arbiter.sv
// Shares one QSPI command driver between two requesters. Each grant runs
// as an atomic sequence: optional WREN, the main op, optional status polls,
// with a one-cycle idle gap after every driver completion.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no command active, arbitrate and latch the winner
// WREN    | Write Enable (06h) active, wait for done
// GAP     | one cycle with command inactive, then enter gap_next
// OP      | main operation active, capture read byte on done
// POLL    | Read Status (05h) active, check busy bit on done
// ACK     | completion pulse already issued, update pointer
module qspi_cmd_arbiter
   import qspi_cmd_pkg::*;
#(
   parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
   input  logic        clk_25M,
   input  logic        I_rst,
   input  logic        W_req0,
   input  logic        W_req1,
   input  logic [3:0]  W_req_type0,
   input  logic [3:0]  W_req_type1,
   input  logic [7:0]  W_req_cmd0,
   input  logic [7:0]  W_req_cmd1,
   input  logic [23:0] W_req_addr0,
   input  logic [23:0] W_req_addr1,
   input  logic [15:0] W_req_data0,
   input  logic [15:0] W_req_data1,
   input  logic        W_done_sig,
   input  logic [7:0]  W_read_data,
   output logic [4:0]  R_cmd_type,
   output logic [7:0]  R_flash_cmd,
   output logic [23:0] R_flash_addr,
   output logic [15:0] R_wr_data,
   output logic        R_ack0,
   output logic        R_ack1,
   output logic [7:0]  R_rdata0,
   output logic [7:0]  R_rdata1,
   output logic        R_err0,
   output logic        R_err1
);

   state_t      state;
   state_t      gap_next;
   logic        sel;
   logic [3:0]  lat_type;
   logic [7:0]  lat_cmd;
   logic [23:0] lat_addr;
   logic [15:0] lat_data;
   logic [7:0]  lat_rdata;
   logic        lat_err;
   logic [15:0] poll_cnt;
   logic [16:0] poll_inc;

   logic        gnt_valid;
   logic        gnt_port;
   logic        done_act;

   logic [3:0]  sel_type;
   logic [7:0]  sel_cmd;
   logic [23:0] sel_addr;
   logic [15:0] sel_data;

   qspi_rr_arb2 u_arb (
      .clk_25M   (clk_25M),
      .I_rst     (I_rst),
      .req0      (W_req0),
      .req1      (W_req1),
      .upd_en    (state == ST_ACK),
      .upd_port  (sel),
      .gnt_valid (gnt_valid),
      .gnt_port  (gnt_port)
   );

   // A done pulse only counts while a command is actually being driven.
   assign done_act = W_done_sig & R_cmd_type[4];
   assign poll_inc = {1'b0, poll_cnt} + 17'd1;

   // Request fields of the port the arbiter would grant this cycle.
   always_comb begin
      if (gnt_port) begin
         sel_type = W_req_type1;
         sel_cmd  = W_req_cmd1;
         sel_addr = W_req_addr1;
         sel_data = W_req_data1;
      end else begin
         sel_type = W_req_type0;
         sel_cmd  = W_req_cmd0;
         sel_addr = W_req_addr0;
         sel_data = W_req_data0;
      end
   end

   // Transaction sequencer with registered command and completion outputs.
   always_ff @(posedge clk_25M) begin
      if (I_rst) begin
         state        <= ST_IDLE;
         gap_next     <= ST_IDLE;
         sel          <= 1'b0;
         lat_type     <= 4'd0;
         lat_cmd      <= 8'd0;
         lat_addr     <= 24'd0;
         lat_data     <= 16'd0;
         lat_rdata    <= 8'd0;
         lat_err      <= 1'b0;
         poll_cnt     <= 16'd0;
         R_cmd_type   <= 5'd0;
         R_flash_cmd  <= 8'd0;
         R_flash_addr <= 24'd0;
         R_wr_data    <= 16'd0;
         R_ack0       <= 1'b0;
         R_ack1       <= 1'b0;
         R_rdata0     <= 8'd0;
         R_rdata1     <= 8'd0;
         R_err0       <= 1'b0;
         R_err1       <= 1'b0;
      end else begin
         R_ack0 <= 1'b0;
         R_ack1 <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (gnt_valid) begin
                  sel      <= gnt_port;
                  lat_type <= sel_type;
                  lat_cmd  <= sel_cmd;
                  lat_addr <= sel_addr;
                  lat_data <= sel_data;
                  lat_err  <= 1'b0;
                  poll_cnt <= 16'd0;
                  if (needs_wren(sel_type)) begin
                     state       <= ST_WREN;
                     R_cmd_type  <= {1'b1, CMD_WREN};
                     R_flash_cmd <= OPC_WREN;
                  end else begin
                     state        <= ST_OP;
                     R_cmd_type   <= {1'b1, sel_type};
                     R_flash_cmd  <= sel_cmd;
                     R_flash_addr <= sel_addr;
                     R_wr_data    <= sel_data;
                  end
               end
            end
            ST_WREN: begin
               if (done_act) begin
                  state       <= ST_GAP;
                  gap_next    <= ST_OP;
                  R_cmd_type  <= 5'd0;
                  R_flash_cmd <= 8'd0;
               end
            end
            ST_OP: begin
               if (done_act) begin
                  lat_rdata   <= W_read_data;
                  state       <= ST_GAP;
                  gap_next    <= needs_poll(lat_type) ? ST_POLL : ST_ACK;
                  R_cmd_type  <= 5'd0;
                  R_flash_cmd <= 8'd0;
               end
            end
            ST_POLL: begin
               if (done_act) begin
                  state       <= ST_GAP;
                  R_cmd_type  <= 5'd0;
                  R_flash_cmd <= 8'd0;
                  if (!W_read_data[0]) begin
                     gap_next <= ST_ACK;
                  end else if (poll_inc >= {1'b0, POLL_MAX}) begin
                     poll_cnt <= POLL_MAX;
                     lat_err  <= 1'b1;
                     gap_next <= ST_ACK;
                  end else begin
                     poll_cnt <= poll_inc[15:0];
                     gap_next <= ST_POLL;
                  end
               end
            end
            ST_GAP: begin
               state <= gap_next;
               case (gap_next)
                  ST_OP: begin
                     poll_cnt     <= 16'd0;
                     R_cmd_type   <= {1'b1, lat_type};
                     R_flash_cmd  <= lat_cmd;
                     R_flash_addr <= lat_addr;
                     R_wr_data    <= lat_data;
                  end
                  ST_POLL: begin
                     R_cmd_type  <= {1'b1, CMD_RDSR};
                     R_flash_cmd <= OPC_RDSR;
                  end
                  ST_ACK: begin
                     if (sel) begin
                        R_ack1   <= 1'b1;
                        R_rdata1 <= lat_rdata;
                        R_err1   <= lat_err;
                     end else begin
                        R_ack0   <= 1'b1;
                        R_rdata0 <= lat_rdata;
                        R_err0   <= lat_err;
                     end
                  end
                  default: begin
                  end
               endcase
            end
            ST_ACK: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qspi_cmd_arbiter.sv
// Directed bench for qspi_cmd_arbiter with a behavioural flash driver and
// scoreboards for the issued command stream and the per-port completions.
module tb_qspi_cmd_arbiter;

   logic        clk_25M = 1'b0;
   logic        I_rst = 1'b1;
   logic        W_req0 = 1'b0, W_req1 = 1'b0;
   logic [3:0]  W_req_type0 = '0, W_req_type1 = '0;
   logic [7:0]  W_req_cmd0 = '0, W_req_cmd1 = '0;
   logic [23:0] W_req_addr0 = '0, W_req_addr1 = '0;
   logic [15:0] W_req_data0 = '0, W_req_data1 = '0;
   logic        W_done_sig = 1'b0;
   logic [7:0]  W_read_data = '0;
   logic [4:0]  R_cmd_type;
   logic [7:0]  R_flash_cmd;
   logic [23:0] R_flash_addr;
   logic [15:0] R_wr_data;
   logic        R_ack0, R_ack1;
   logic [7:0]  R_rdata0, R_rdata1;
   logic        R_err0, R_err1;

   qspi_cmd_arbiter #(.POLL_MAX(16'd4)) dut (
      .clk_25M      (clk_25M),
      .I_rst        (I_rst),
      .W_req0       (W_req0),
      .W_req1       (W_req1),
      .W_req_type0  (W_req_type0),
      .W_req_type1  (W_req_type1),
      .W_req_cmd0   (W_req_cmd0),
      .W_req_cmd1   (W_req_cmd1),
      .W_req_addr0  (W_req_addr0),
      .W_req_addr1  (W_req_addr1),
      .W_req_data0  (W_req_data0),
      .W_req_data1  (W_req_data1),
      .W_done_sig   (W_done_sig),
      .W_read_data  (W_read_data),
      .R_cmd_type   (R_cmd_type),
      .R_flash_cmd  (R_flash_cmd),
      .R_flash_addr (R_flash_addr),
      .R_wr_data    (R_wr_data),
      .R_ack0       (R_ack0),
      .R_ack1       (R_ack1),
      .R_rdata0     (R_rdata0),
      .R_rdata1     (R_rdata1),
      .R_err0       (R_err0),
      .R_err1       (R_err1)
   );

   always #20 clk_25M = ~clk_25M;

   typedef struct packed {
      logic [4:0]  t;
      logic [7:0]  c;
      logic [23:0] a;
      logic [15:0] d;
      logic        chk_a;
      logic        cont;
   } exp_cmd_t;

   typedef struct packed {
      logic [1:0] p;
      logic [7:0] rd;
      logic       er;
   } exp_ack_t;

   exp_cmd_t   exp_cmd_q[$];
   exp_ack_t   exp_ack_q[$];
   logic [7:0] status_q[$];

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   last_gap_cyc = 0;
   int   ack_total = 0;
   int   done_delay = 4;
   logic [7:0] op_data = 8'h00;
   bit   spurious_gap = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected command stream and completion for one granted request.
   task automatic push_txn(input logic p, input logic [3:0] t, input logic [7:0] c,
                           input logic [23:0] a, input logic [15:0] d, input int npoll,
                           input logic [7:0] rd, input logic er, input bit with_ack);
      bit wr;
      wr = (t == 4'd2) || (t == 4'd5) || (t == 4'd6) || (t == 4'd8);
      if (wr) exp_cmd_q.push_back('{5'h11, 8'h06, 24'h0, 16'h0, 1'b0, 1'b0});
      exp_cmd_q.push_back('{{1'b1, t}, c, a, d, 1'b1, wr});
      for (int i = 0; i < npoll; i++)
         exp_cmd_q.push_back('{5'h13, 8'h05, 24'h0, 16'h0, 1'b0, 1'b1});
      if (with_ack) exp_ack_q.push_back('{(p ? 2'd1 : 2'd0), rd, er});
   endtask

   task automatic set_port(input logic p, input logic [3:0] t, input logic [7:0] c,
                           input logic [23:0] a, input logic [15:0] d);
      if (p) begin
         W_req_type1 = t; W_req_cmd1 = c; W_req_addr1 = a; W_req_data1 = d;
      end else begin
         W_req_type0 = t; W_req_cmd0 = c; W_req_addr0 = a; W_req_data0 = d;
      end
   endtask

   task automatic wait_acks(input int target, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_25M);
         if (ack_total >= target) begin
            ok = 1'b1;
            break;
         end
      end
      check("ack_wait", ok, 1);
   endtask

   task automatic wait_cmd(input logic [4:0] t, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_25M);
         if (R_cmd_type == t) begin
            ok = 1'b1;
            break;
         end
      end
      check("cmd_wait", ok, 1);
   endtask

   initial forever begin
      @(posedge clk_25M);
      cyc++;
   end

   // Flash driver model: compares each started command, answers after
   // done_delay cycles and checks the one-cycle idle gap that follows.
   initial begin
      exp_cmd_t e;
      bit live;
      forever begin
         @(negedge clk_25M);
         W_done_sig = 1'b0;
         if (R_cmd_type[4]) begin
            if (exp_cmd_q.size() > 0) e = exp_cmd_q.pop_front();
            else e = '0;
            check("cmd", {R_cmd_type, R_flash_cmd}, {e.t, e.c});
            if (e.chk_a) check("addr_data", {R_flash_addr, R_wr_data}, {e.a, e.d});
            if (e.cont) check("gap_len", cyc - last_gap_cyc, 1);
            live = 1'b1;
            for (int i = 1; i < done_delay; i++) begin
               @(negedge clk_25M);
               if (!R_cmd_type[4]) begin
                  live = 1'b0;
                  break;
               end
            end
            if (live) begin
               if (R_flash_cmd == 8'h05)
                  W_read_data = (status_q.size() > 0) ? status_q.pop_front() : 8'h00;
               else
                  W_read_data = op_data;
               W_done_sig = 1'b1;
               @(negedge clk_25M);
               W_done_sig = 1'b0;
               check("gap_zero", R_cmd_type, 5'd0);
               last_gap_cyc = cyc;
               if (spurious_gap) W_done_sig = 1'b1;
            end
         end
      end
   end

   // Completion monitor: scoreboard compare, ack-after-gap timing, req drop.
   initial begin
      exp_ack_t e;
      exp_ack_t o;
      forever begin
         @(negedge clk_25M);
         if (R_ack0 || R_ack1) begin
            o.p  = (R_ack0 && R_ack1) ? 2'd2 : (R_ack1 ? 2'd1 : 2'd0);
            o.rd = R_ack0 ? R_rdata0 : R_rdata1;
            o.er = R_ack0 ? R_err0 : R_err1;
            if (exp_ack_q.size() > 0) e = exp_ack_q.pop_front();
            else e = '1;
            check("ack", o, e);
            check("ack_lat", cyc - last_gap_cyc, 1);
            if (R_ack0) W_req0 = 1'b0;
            if (R_ack1) W_req1 = 1'b0;
            ack_total++;
         end
      end
   end

   initial begin
      #(40 * 20000);
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk_25M);
      check("rst_cmd", {R_cmd_type, R_flash_cmd, R_flash_addr, R_wr_data}, 0);
      check("rst_ack", {R_ack0, R_ack1, R_err0, R_err1, R_rdata0, R_rdata1}, 0);
      I_rst = 1'b0;
      @(negedge clk_25M);

      // Read ID on port 0, no write enable, no polling.
      done_delay = 10;
      op_data = 8'h20;
      push_txn(1'b0, 4'd0, 8'h9F, 24'h0, 16'h0, 0, 8'h20, 1'b0, 1'b1);
      set_port(1'b0, 4'd0, 8'h9F, 24'h0, 16'h0);
      W_req0 = 1'b1;
      wait_acks(1, 100);
      check("t1_left", exp_cmd_q.size(), 0);

      // Sector erase on port 1 with two busy polls; fields scrambled after grant.
      done_delay = 3;
      op_data = 8'h5A;
      status_q = '{8'h01, 8'h01, 8'h00};
      push_txn(1'b1, 4'd2, 8'hD8, 24'h010000, 16'h0, 3, 8'h5A, 1'b0, 1'b1);
      set_port(1'b1, 4'd2, 8'hD8, 24'h010000, 16'h0);
      W_req1 = 1'b1;
      wait_cmd(5'h11, 50);
      set_port(1'b1, 4'd0, 8'h00, 24'hFFFFFF, 16'hFFFF);
      wait_acks(2, 200);
      check("t2_left", exp_cmd_q.size() + status_q.size(), 0);
      check("t2_rdata0_hold", R_rdata0, 8'h20);

      // Simultaneous quad page programs, two rounds.
      done_delay = 2;
      op_data = 8'h33;
      push_txn(1'b0, 4'd8, 8'h32, 24'h000100, 16'h1111, 1, 8'h33, 1'b0, 1'b1);
      push_txn(1'b1, 4'd8, 8'h32, 24'h000200, 16'h2222, 1, 8'h33, 1'b0, 1'b1);
      set_port(1'b0, 4'd8, 8'h32, 24'h000100, 16'h1111);
      set_port(1'b1, 4'd8, 8'h32, 24'h000200, 16'h2222);
      W_req0 = 1'b1;
      W_req1 = 1'b1;
      wait_acks(4, 200);
      push_txn(1'b0, 4'd8, 8'h32, 24'h000300, 16'h3333, 1, 8'h33, 1'b0, 1'b1);
      push_txn(1'b1, 4'd8, 8'h32, 24'h000400, 16'h4444, 1, 8'h33, 1'b0, 1'b1);
      set_port(1'b0, 4'd8, 8'h32, 24'h000300, 16'h3333);
      set_port(1'b1, 4'd8, 8'h32, 24'h000400, 16'h4444);
      W_req0 = 1'b1;
      W_req1 = 1'b1;
      wait_acks(6, 200);
      check("t3_left", exp_cmd_q.size() + exp_ack_q.size(), 0);

      // Status stuck busy: four polls then error.
      op_data = 8'h44;
      status_q = '{8'h01, 8'h01, 8'h01, 8'h01};
      push_txn(1'b1, 4'd6, 8'hB1, 24'h0, 16'hABCD, 4, 8'h44, 1'b1, 1'b1);
      set_port(1'b1, 4'd6, 8'hB1, 24'h0, 16'hABCD);
      W_req1 = 1'b1;
      wait_acks(7, 300);
      check("t4_left", exp_cmd_q.size() + status_q.size(), 0);
      check("t4_err_hold", {R_err1, R_rdata1}, {1'b1, 8'h44});

      // Reset during a poll; the still-high request restarts from WREN.
      done_delay = 4;
      op_data = 8'h55;
      push_txn(1'b0, 4'd5, 8'h02, 24'h123456, 16'h00FF, 1, 8'h55, 1'b0, 1'b0);
      push_txn(1'b0, 4'd5, 8'h02, 24'h123456, 16'h00FF, 1, 8'h55, 1'b0, 1'b1);
      set_port(1'b0, 4'd5, 8'h02, 24'h123456, 16'h00FF);
      W_req0 = 1'b1;
      wait_cmd(5'h13, 100);
      I_rst = 1'b1;
      @(negedge clk_25M);
      check("t5_rst_cmd", {R_cmd_type, R_flash_cmd, R_flash_addr, R_wr_data}, 0);
      check("t5_rst_ack", {R_ack0, R_ack1, R_err0, R_err1, R_rdata0, R_rdata1}, 0);
      I_rst = 1'b0;
      check("t5_no_ack", ack_total, 7);
      wait_acks(8, 200);
      check("t5_left", exp_cmd_q.size() + exp_ack_q.size(), 0);

      // Spurious done in IDLE, then in every GAP of an erase.
      repeat (2) @(negedge clk_25M);
      #1 W_done_sig = 1'b1;
      repeat (3) @(negedge clk_25M);
      check("t6_idle_cmd", R_cmd_type, 5'd0);
      check("t6_idle_ack", ack_total, 8);
      done_delay = 1;
      op_data = 8'h66;
      spurious_gap = 1'b1;
      push_txn(1'b1, 4'd2, 8'h20, 24'h00ABCD, 16'h0, 1, 8'h66, 1'b0, 1'b1);
      set_port(1'b1, 4'd2, 8'h20, 24'h00ABCD, 16'h0);
      W_req1 = 1'b1;
      wait_acks(9, 200);
      spurious_gap = 1'b0;
      repeat (4) @(negedge clk_25M);
      check("t6_left", exp_cmd_q.size() + exp_ack_q.size(), 0);
      check("t6_total_acks", ack_total, 9);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
